param_dp_mem: RTL and testbench

PARAM_DP_MEM -- requirements
Module: param_dp_mem

---
 rtl/param_dp_mem.sv | 149 ++++++++++++++
 tb/tb_param_dp_mem.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_dp_mem.sv
// Parameterised simple dual-port memory with byte-lane write enables,
// configurable read latency and read-during-write behaviour, and a
// sequential self-clear that sweeps every address after reset or on request.
module param_dp_mem #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int BYTE_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clr,
  input  logic                       i_w_en,
  input  logic [DATA_W/BYTE_W-1:0]   i_w_be,
  input  logic [ADDR_W-1:0]          i_w_addr,
  input  logic [DATA_W-1:0]          i_d_in,
  input  logic                       i_r_en,
  input  logic [ADDR_W-1:0]          i_r_addr,
  output logic [DATA_W-1:0]          o_d_out,
  output logic                       o_r_valid,
  output logic                       o_ready
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_acc;
  logic                rd_acc;
  logic [DATA_W-1:0]   rd_word;

  // Replace the lanes selected by be in old_w with the matching lanes of new_w.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) res[k*BYTE_W +: BYTE_W] = new_w[k*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

  assign o_ready = (state == READY);
  assign wr_acc  = o_ready & i_w_en;
  assign rd_acc  = o_ready & i_r_en;

  // Clear sequencer: sweep clr_cnt over every address, then accept traffic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (i_clr) begin
            clr_cnt <= '0;
          end else if (&clr_cnt) begin
            state   <= READY;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        READY: begin
          if (i_clr) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // Storage array: zero-fill during CLEAR, lane-masked writes when READY.
  // Left without reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (!o_ready) begin
      mem[clr_cnt] <= '0;
    end else if (i_w_en) begin
      for (int k = 0; k < NB; k++) begin
        if (i_w_be[k]) mem[i_w_addr][k*BYTE_W +: BYTE_W] <= i_d_in[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read word with optional write-through of the lanes being written this cycle.
  always_comb begin
    rd_word = mem[i_r_addr];
    if ((RDW_MODE != 0) && wr_acc && (i_w_addr == i_r_addr)) begin
      rd_word = merge_lanes(mem[i_r_addr], i_d_in, i_w_be);
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] rd_p0;
      logic              vld_p0;

      // ---- stage p0: array read ----
      // Capture the array word; data path carries no reset.
      always_ff @(posedge i_clk) begin
        if (rd_acc) rd_p0 <= rd_word;
      end

      // Valid bit for stage p0.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) vld_p0 <= 1'b0;
        else          vld_p0 <= rd_acc;
      end

      // ---- stage p1: output register ----
      // Output register; holds the last result when nothing new arrives.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          o_d_out   <= '0;
          o_r_valid <= 1'b0;
        end else begin
          o_r_valid <= vld_p0;
          if (vld_p0) o_d_out <= rd_p0;
        end
      end
    end else begin : g_lat1
      // ---- stage p0: array read straight into the output register ----
      // Output register; holds the last result when nothing new arrives.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          o_d_out   <= '0;
          o_r_valid <= 1'b0;
        end else begin
          o_r_valid <= rd_acc;
          if (rd_acc) o_d_out <= rd_word;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_param_dp_mem.sv
// Directed bench for param_dp_mem: three instances share one stimulus stream
// (defaults, write-through read-during-write, two-cycle read latency).
module tb_param_dp_mem;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_clr;
  logic        i_w_en;
  logic [1:0]  i_w_be;
  logic [9:0]  i_w_addr;
  logic [15:0] i_d_in;
  logic        i_r_en;
  logic [9:0]  i_r_addr;

  logic [15:0] d0, d1, d2;
  logic        v0, v1, v2;
  logic        rdy0, rdy1, rdy2;

  int n_chk  = 0;
  int n_fail = 0;

  param_dp_mem #(.RD_LAT(1), .RDW_MODE(0)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr), .i_w_en(i_w_en), .i_w_be(i_w_be),
    .i_w_addr(i_w_addr), .i_d_in(i_d_in), .i_r_en(i_r_en), .i_r_addr(i_r_addr),
    .o_d_out(d0), .o_r_valid(v0), .o_ready(rdy0));

  param_dp_mem #(.RD_LAT(1), .RDW_MODE(1)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr), .i_w_en(i_w_en), .i_w_be(i_w_be),
    .i_w_addr(i_w_addr), .i_d_in(i_d_in), .i_r_en(i_r_en), .i_r_addr(i_r_addr),
    .o_d_out(d1), .o_r_valid(v1), .o_ready(rdy1));

  param_dp_mem #(.RD_LAT(2), .RDW_MODE(0)) dut2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr), .i_w_en(i_w_en), .i_w_be(i_w_be),
    .i_w_addr(i_w_addr), .i_d_in(i_d_in), .i_r_en(i_r_en), .i_r_addr(i_r_addr),
    .o_d_out(d2), .o_r_valid(v2), .o_ready(rdy2));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        w_en;
    logic [1:0]  be;
    logic [9:0]  wa;
    logic [15:0] din;
    logic        r_en;
    logic [9:0]  ra;
    logic [15:0] exp0;   // expected for RDW_MODE = 0
    logic [15:0] exp1;   // expected for RDW_MODE = 1
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_clr    = 1'b0;
    i_w_en   = 1'b0;
    i_w_be   = 2'b00;
    i_w_addr = '0;
    i_d_in   = '0;
    i_r_en   = 1'b0;
    i_r_addr = '0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
    @(negedge i_clk);
    i_w_en = 1'b1; i_w_addr = a; i_d_in = d; i_w_be = be;
    @(negedge i_clk);
    i_w_en = 1'b0; i_w_be = 2'b00;
  endtask

  // Count edges until o_ready rises, starting from the current point.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge i_clk); #1;
      cycles++;
      if (rdy0) break;
    end
  endtask

  int cyc;
  int bad;
  logic [15:0] last0, last1;

  initial begin
    vecs[0]  = '{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd100,  16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 2'b01, 10'd5,    16'hABCD, 1'b0, 10'd0,    16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd5,    16'h00CD, 16'h00CD};
    vecs[3]  = '{1'b1, 2'b10, 10'd5,    16'h1200, 1'b0, 10'd0,    16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd5,    16'h12CD, 16'h12CD};
    vecs[5]  = '{1'b1, 2'b11, 10'd7,    16'h1111, 1'b0, 10'd0,    16'h0000, 16'h0000};
    vecs[6]  = '{1'b1, 2'b11, 10'd7,    16'h5555, 1'b1, 10'd7,    16'h1111, 16'h5555};
    vecs[7]  = '{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd7,    16'h5555, 16'h5555};
    vecs[8]  = '{1'b1, 2'b00, 10'd9,    16'hBEEF, 1'b1, 10'd9,    16'h0000, 16'h0000};
    vecs[9]  = '{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd9,    16'h0000, 16'h0000};
    vecs[10] = '{1'b1, 2'b11, 10'd8,    16'h2222, 1'b1, 10'd7,    16'h5555, 16'h5555};
    vecs[11] = '{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd8,    16'h2222, 16'h2222};
    vecs[12] = '{1'b1, 2'b01, 10'd10,   16'hAAAA, 1'b1, 10'd10,   16'h0000, 16'h00AA};
    vecs[13] = '{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd1023, 16'h0000, 16'h0000};
    vecs[14] = '{1'b1, 2'b11, 10'd1023, 16'h7777, 1'b0, 10'd0,    16'h0000, 16'h0000};
    vecs[15] = '{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd1023, 16'h7777, 16'h7777};

    idle_inputs();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_d_out",   {16'h0, d0}, 32'h0);
    chk("reset_r_valid", {31'h0, v0 | v1 | v2}, 32'h0);
    chk("reset_ready",   {31'h0, rdy0 | rdy1 | rdy2}, 32'h0);

    // Reset release: full clear before ready
    @(negedge i_clk);
    i_rst_n = 1'b1;
    wait_ready(cyc);
    chk("init_clear_cycles", cyc, 1024);
    chk("init_ready_all", {29'h0, rdy0, rdy1, rdy2}, 32'h7);

    // Table-driven single transactions
    last0 = 16'h0;
    last1 = 16'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge i_clk);
      i_w_en = vecs[i].w_en; i_w_be = vecs[i].be; i_w_addr = vecs[i].wa; i_d_in = vecs[i].din;
      i_r_en = vecs[i].r_en; i_r_addr = vecs[i].ra;
      @(posedge i_clk); #1;
      if (vecs[i].r_en) begin
        chk($sformatf("vec%0d_valid0", i), {31'h0, v0}, 32'h1);
        chk($sformatf("vec%0d_data0", i), {16'h0, d0}, {16'h0, vecs[i].exp0});
        chk($sformatf("vec%0d_valid1", i), {31'h0, v1}, 32'h1);
        chk($sformatf("vec%0d_data1", i), {16'h0, d1}, {16'h0, vecs[i].exp1});
        last0 = vecs[i].exp0;
        last1 = vecs[i].exp1;
      end else begin
        chk($sformatf("vec%0d_novalid0", i), {31'h0, v0 | v1}, 32'h0);
        chk($sformatf("vec%0d_hold0", i), {16'h0, d0}, {16'h0, last0});
        chk($sformatf("vec%0d_hold1", i), {16'h0, d1}, {16'h0, last1});
      end
      chk($sformatf("vec%0d_lat2_early", i), {31'h0, v2}, 32'h0);
      @(negedge i_clk);
      idle_inputs();
      @(posedge i_clk); #1;
      chk($sformatf("vec%0d_valid2", i), {31'h0, v2}, {31'h0, vecs[i].r_en});
      if (vecs[i].r_en) chk($sformatf("vec%0d_data2", i), {16'h0, d2}, {16'h0, vecs[i].exp0});
      chk($sformatf("vec%0d_valid0_drop", i), {31'h0, v0}, 32'h0);
    end

    // Back-to-back reads, two-cycle latency
    do_write(10'd0, 16'h000A, 2'b11);
    do_write(10'd1, 16'h000B, 2'b11);
    do_write(10'd2, 16'h000C, 2'b11);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      i_r_en   = (i < 3);
      i_r_addr = 10'(i < 3 ? i : 0);
      @(posedge i_clk); #1;
      chk($sformatf("b2b_valid2_c%0d", i), {31'h0, v2}, {31'h0, (i >= 1 && i <= 3)});
      if (i >= 1 && i <= 3) chk($sformatf("b2b_data2_c%0d", i), {16'h0, d2}, 32'(16'h000A + i - 1));
      chk($sformatf("b2b_valid0_c%0d", i), {31'h0, v0}, {31'h0, (i <= 2)});
      if (i <= 2) chk($sformatf("b2b_data0_c%0d", i), {16'h0, d0}, 32'(16'h000A + i));
    end
    @(negedge i_clk);
    idle_inputs();

    // Clear request with a read in flight; traffic during clear is dropped
    do_write(10'd3, 16'hFFFF, 2'b11);
    i_r_en = 1'b1; i_r_addr = 10'd3; i_clr = 1'b1;
    @(posedge i_clk); #1;
    chk("clr_inflight_valid0", {31'h0, v0}, 32'h1);
    chk("clr_inflight_data0", {16'h0, d0}, 32'h0000FFFF);
    chk("clr_ready_low", {31'h0, rdy0}, 32'h0);
    cyc = 0;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge i_clk);
      i_clr = 1'b0;
      i_w_en = 1'b1; i_w_be = 2'b11; i_w_addr = 10'd4; i_d_in = 16'h1234;
      i_r_en = 1'b1; i_r_addr = 10'd3;
      @(posedge i_clk); #1;
      cyc++;
      if (cyc == 1) begin
        chk("clr_inflight_valid2", {31'h0, v2}, 32'h1);
        chk("clr_inflight_data2", {16'h0, d2}, 32'h0000FFFF);
        if (v0 | v1) bad++;
      end else if (v0 | v1 | v2) begin
        bad++;
      end
      if (rdy0) break;
    end
    @(negedge i_clk);
    idle_inputs();
    chk("clr_cycles", cyc, 1024);
    chk("clr_no_valid_during_clear", bad, 0);
    i_r_en = 1'b1; i_r_addr = 10'd3;
    @(posedge i_clk); #1;
    chk("clr_addr3_valid", {31'h0, v0}, 32'h1);
    chk("clr_addr3_zero", {16'h0, d0}, 32'h0);
    @(negedge i_clk);
    i_r_addr = 10'd4;
    @(posedge i_clk); #1;
    chk("clr_dropped_write", {16'h0, d0}, 32'h0);
    @(negedge i_clk);
    idle_inputs();

    // Reset in the middle of a clear restarts the sweep
    do_write(10'd20, 16'h3C3C, 2'b11);
    i_r_en = 1'b1; i_r_addr = 10'd20; i_clr = 1'b1;
    @(posedge i_clk); #1;
    chk("rstmid_pre_data0", {16'h0, d0}, 32'h00003C3C);
    @(negedge i_clk);
    idle_inputs();
    repeat (499) @(posedge i_clk);
    #2;
    chk("rstmid_pre_reset_data0", {16'h0, d0}, 32'h00003C3C);
    i_rst_n = 1'b0;
    #1;
    chk("rstmid_d_out_zero", {d1, d0}, 32'h0);
    chk("rstmid_d2_zero", {16'h0, d2}, 32'h0);
    chk("rstmid_valid_zero", {31'h0, v0 | v1 | v2}, 32'h0);
    chk("rstmid_ready_low", {31'h0, rdy0}, 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    wait_ready(cyc);
    chk("rstmid_clear_cycles", cyc, 1024);
    @(negedge i_clk);
    i_r_en = 1'b1; i_r_addr = 10'd20;
    @(posedge i_clk); #1;
    chk("rstmid_addr20_valid", {31'h0, v0}, 32'h1);
    chk("rstmid_addr20_zero", {16'h0, d0}, 32'h0);
    @(negedge i_clk);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
